// File: rtl/cpu_pkg.sv
// Shared CPU constants: next-PC select encodings and the instruction-memory
// address map used by the IFU, instruction memory and CP0.
package cpu_pkg;

  localparam logic [1:0] NPC_SEQ = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  localparam logic [31:0] PC_RESET   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
  localparam logic [31:0] IM_TOP     = 32'h0000_4FFC;

endpackage

// File: rtl/ifu_npc_gen.sv
// npc_gen: combinational next-PC mux for sequential, branch, j/jal and jr
// redirects. Branch and jump targets are relative to the D-stage instruction.
module npc_gen
  import cpu_pkg::*;
(
  input  logic [31:0] pc_f,
  input  logic [31:0] pc_d,
  input  logic [25:0] imm26_d,
  input  logic [1:0]  npc_sel,
  input  logic [31:0] rs_val,
  output logic [31:0] npc
);

  logic [31:0] br_off;

  assign br_off = {{14{imm26_d[15]}}, imm26_d[15:0], 2'b00};

  always_comb begin
    npc = pc_f + 32'd4;
    unique case (npc_sel)
      NPC_BR:  npc = pc_d + 32'd4 + br_off;
      NPC_J:   npc = {pc_d[31:28], imm26_d, 2'b00};
      NPC_JR:  npc = rs_val;
      default: npc = pc_f + 32'd4;
    endcase
  end

endmodule

// File: rtl/ifu.sv
// ifu: fetch PC register, F/D pipeline register and optional fetch address
// check (enabled by defining IFU_ADDR_CHECK_EN).
module ifu
  import cpu_pkg::*;
#(
  parameter logic [31:0] PC_RESET   = cpu_pkg::PC_RESET,
  parameter logic [31:0] EXC_VECTOR = cpu_pkg::EXC_VECTOR,
  parameter logic [31:0] IM_TOP     = cpu_pkg::IM_TOP
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc_f,
  input  logic [31:0] instr_f,
  input  logic        stall,
  input  logic [1:0]  npc_sel,
  input  logic        jump_d,
  input  logic [31:0] rs_val,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic        bd_d,
  output logic        adel_d
);

  logic [31:0] npc;
  logic        addr_err;

  npc_gen u_npc_gen (
    .pc_f    (pc_f),
    .pc_d    (pc_d),
    .imm26_d (instr_d[25:0]),
    .npc_sel (npc_sel),
    .rs_val  (rs_val),
    .npc     (npc)
  );

`ifdef IFU_ADDR_CHECK_EN
  assign addr_err = (pc_f[1:0] != 2'b00) || (pc_f < PC_RESET) || (pc_f > IM_TOP);
`else
  logic unused_cfg;
  // The upper bound only matters to the range check; keep it referenced.
  assign unused_cfg = ^IM_TOP;
  assign addr_err   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_f    <= PC_RESET;
      instr_d <= '0;
      pc_d    <= '0;
      bd_d    <= 1'b0;
      adel_d  <= 1'b0;
    end else if (exc_req || eret) begin
      // Flush wins over stall; ERET has no delay slot.
      pc_f    <= exc_req ? EXC_VECTOR : epc;
      instr_d <= '0;
      pc_d    <= '0;
      bd_d    <= 1'b0;
      adel_d  <= 1'b0;
    end else if (!stall) begin
      pc_f    <= npc;
      instr_d <= addr_err ? 32'd0 : instr_f;
      pc_d    <= pc_f;
      bd_d    <= jump_d;
      adel_d  <= addr_err;
    end
  end

endmodule

// File: tb/tb_ifu.sv
// tb_ifu: randomized + directed stimulus for ifu, checked by a scoreboard fed
// from a behavioural fetch model. Honours IFU_ADDR_CHECK_EN like the RTL.
module tb_ifu;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_f;
  logic [31:0] instr_f;
  logic        stall;
  logic [1:0]  npc_sel;
  logic        jump_d;
  logic [31:0] rs_val;
  logic        exc_req;
  logic        eret;
  logic [31:0] epc;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic        bd_d;
  logic        adel_d;

  typedef struct packed {
    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic        bd_d;
    logic        adel_d;
  } obs_t;

  logic [31:0] mem [0:4095];
  obs_t        sb[$];
  obs_t        m;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  assign instr_f = mem[pc_f[13:2]];

  ifu dut (
    .clk     (clk),
    .reset   (reset),
    .pc_f    (pc_f),
    .instr_f (instr_f),
    .stall   (stall),
    .npc_sel (npc_sel),
    .jump_d  (jump_d),
    .rs_val  (rs_val),
    .exc_req (exc_req),
    .eret    (eret),
    .epc     (epc),
    .instr_d (instr_d),
    .pc_d    (pc_d),
    .bd_d    (bd_d),
    .adel_d  (adel_d)
  );

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem[a[13:2]];
  endfunction

  function automatic bit bad_addr(input logic [31:0] a);
`ifdef IFU_ADDR_CHECK_EN
    return (a % 4 != 0) || (a < 32'h3000) || (a > 32'h4FFC);
`else
    return 1'b0;
`endif
  endfunction

  // Behavioural model: advance one cycle from the spec's priority rules.
  task automatic step(input logic rst, input logic stl, input logic [1:0] sel,
                      input logic jd, input logic [31:0] rs, input logic ex,
                      input logic er, input logic [31:0] ep);
    obs_t        n;
    logic [31:0] off;
    reset = rst; stall = stl; npc_sel = sel; jump_d = jd;
    rs_val = rs; exc_req = ex; eret = er; epc = ep;
    n = m;
    if (!rst) begin
      n = '{pc_f: 32'h3000, instr_d: 0, pc_d: 0, bd_d: 0, adel_d: 0};
    end else if (ex || er) begin
      n = '{pc_f: ex ? 32'h4180 : ep, instr_d: 0, pc_d: 0, bd_d: 0, adel_d: 0};
    end else if (!stl) begin
      off = 32'($signed(m.instr_d[15:0])) * 4;
      case (sel)
        2'd1:    n.pc_f = m.pc_d + 4 + off;
        2'd2:    n.pc_f = (m.pc_d & 32'hF000_0000) | ((m.instr_d & 32'h03FF_FFFF) * 4);
        2'd3:    n.pc_f = rs;
        default: n.pc_f = m.pc_f + 4;
      endcase
      n.pc_d    = m.pc_f;
      n.bd_d    = jd;
      n.adel_d  = bad_addr(m.pc_f);
      n.instr_d = n.adel_d ? 32'd0 : rd(m.pc_f);
    end
    m = n;
    sb.push_back(n);
    @(posedge clk);
    #2;
  endtask

  task automatic seq();
    step(1, 0, 2'd0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    obs_t e, a;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      a = '{pc_f: pc_f, instr_d: instr_d, pc_d: pc_d, bd_d: bd_d, adel_d: adel_d};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL scoreboard @%0t: got pc_f=%h instr_d=%h pc_d=%h bd=%b adel=%b expected pc_f=%h instr_d=%h pc_d=%h bd=%b adel=%b",
                 $time, a.pc_f, a.instr_d, a.pc_d, a.bd_d, a.adel_d,
                 e.pc_f, e.instr_d, e.pc_d, e.bd_d, e.adel_d);
      end
    end
  end

  initial begin
    logic [31:0] a;
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    a = 32'h3010; mem[a[13:2]] = 32'h1000_FFFE;
    a = 32'h300C; mem[a[13:2]] = 32'h0800_0C40;
    reset = 0; stall = 0; npc_sel = 0; jump_d = 0; rs_val = 0;
    exc_req = 0; eret = 0; epc = 0;

    step(0, 0, 2'd0, 0, 0, 0, 0, 0);
    step(0, 0, 2'd0, 0, 0, 0, 0, 0);
    chk("rst_pc_f", pc_f, 32'h3000);
    chk("rst_instr_d", instr_d, 32'h0);
    chk("rst_pc_d", pc_d, 32'h0);
    chk("rst_bd_adel", {30'd0, bd_d, adel_d}, 32'h0);

    seq();
    chk("seq1_pc_f", pc_f, 32'h3004);
    chk("seq1_instr_d", instr_d, rd(32'h3000));
    seq();
    chk("seq2_pc_f", pc_f, 32'h3008);
    seq(); seq(); seq();
    chk("seq_pc_d", pc_d, 32'h3010);

    step(1, 0, 2'd1, 1, 0, 0, 0, 0);
    chk("br_pc_f", pc_f, 32'h300C);
    chk("br_slot_pc_d", pc_d, 32'h3014);
    chk("br_slot_bd", {31'd0, bd_d}, 32'd1);

    seq();
    for (int i = 0; i < 3; i++) step(1, 1, 2'd2, 0, 0, 0, 0, 0);
    chk("stall_pc_f", pc_f, 32'h3010);
    chk("stall_pc_d", pc_d, 32'h300C);
    step(1, 0, 2'd2, 1, 0, 0, 0, 0);
    chk("j_pc_f", pc_f, 32'h3100);

    step(1, 1, 2'd0, 0, 0, 1, 0, 0);
    chk("exc_pc_f", pc_f, 32'h4180);
    chk("exc_instr_d", instr_d, 32'h0);
    step(1, 0, 2'd0, 0, 0, 0, 1, 32'h3020);
    chk("eret_pc_f", pc_f, 32'h3020);
    chk("eret_pc_d", pc_d, 32'h0);

    step(1, 0, 2'd3, 0, 32'h3002, 0, 0, 0);
    chk("jr_pc_f", pc_f, 32'h3002);
    seq();
    chk("adel_pc_d", pc_d, 32'h3002);
`ifdef IFU_ADDR_CHECK_EN
    chk("adel_flag", {31'd0, adel_d}, 32'd1);
    chk("adel_instr_d", instr_d, 32'h0);
`else
    chk("adel_flag", {31'd0, adel_d}, 32'd0);
    chk("adel_instr_d", instr_d, rd(32'h3002));
`endif

    step(1, 0, 2'd0, 0, 0, 1, 1, 32'h3040);
    chk("exc_eret_pc_f", pc_f, 32'h4180);
    seq();
    step(0, 0, 2'd1, 1, 0, 0, 0, 0);
    chk("rst_br_pc_f", pc_f, 32'h3000);

    for (int i = 0; i < 400; i++) begin
      logic        r_rst, r_stl, r_ex, r_er, r_jd;
      logic [1:0]  r_sel;
      logic [31:0] r_rs, r_ep;
      r_rst = ($urandom_range(63) != 0);
      r_stl = ($urandom_range(3) == 0);
      r_ex  = ($urandom_range(31) == 0);
      r_er  = ($urandom_range(31) == 0);
      r_sel = ($urandom_range(2) == 0) ? 2'(($urandom_range(2)) + 1) : 2'd0;
      r_jd  = $urandom_range(1);
      r_rs  = ($urandom_range(7) == 0) ? $urandom : 32'h3000 + 4 * $urandom_range(2047);
      r_ep  = ($urandom_range(7) == 0) ? $urandom : 32'h3000 + 4 * $urandom_range(2047);
      step(r_rst, r_stl, r_sel, r_jd, r_rs, r_ex, r_er, r_ep);
    end

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d entries left expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ifu.md
# ifu

Instruction-fetch unit: the PC-driving side of the instruction memory. It owns the fetch PC register, which the instruction memory decodes against base 0x3000. It also selects the next PC: sequential, branch, jump, register jump, exception vector, or ERET return. It registers the fetched word into the F/D pipeline register with stall and flush control.

## Interface
Parameters:
- PC_RESET, 32'h0000_3000, fetch address after reset
- EXC_VECTOR, 32'h0000_4180, exception handler entry
- IM_TOP, 32'h0000_4FFC, highest valid fetch address

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-low reset
- pc_f  out  32  fetch address to instruction memory
- instr_f  in  32  word returned combinationally by instruction memory for pc_f
- stall  in  1  hold pc_f and the F/D register
- npc_sel  in  2  redirect from the D stage: 00 sequential, 01 branch taken, 10 j/jal, 11 jr
- jump_d  in  1  the D-stage instruction is a branch or jump, whether taken or not
- rs_val  in  32  jr target
- exc_req  in  1  exception taken; go to EXC_VECTOR
- eret  in  1  return from exception; go to epc
- epc  in  32  return address
- instr_d  out  32  F/D instruction
- pc_d  out  32  F/D PC
- bd_d  out  1  the F/D instruction is in a delay slot
- adel_d  out  1  fetch address error on the F/D instruction

## Operation
- Next-PC priority, evaluated each cycle:
  - exc_req: EXC_VECTOR
  - else eret: epc
  - else stall: hold
  - else npc_sel selects one of:
    - 01: pc_d + 4 + (sext(instr_d[15:0]) << 2)
    - 10: {pc_d[31:28], instr_d[25:0], 2'b00}
    - 11: rs_val
    - 00: pc_f + 4
- F/D register:
  - On exc_req or eret: flush to instr_d=0 (nop), pc_d=0, bd_d=0, adel_d=0. Flush overrides stall.
  - Else on stall: hold all F/D outputs.
  - Else load instr_d=instr_f, pc_d=pc_f, bd_d=jump_d.
- Delay slots:
  - A redirect does not squash the instruction in F. That instruction enters D with bd_d=1.
  - ERET has no delay slot; it flushes.
- Address arithmetic is 32-bit modulo 2^32. Wrap-around is not trapped separately; the range check covers it.
- Address error (see Configuration): an error exists if pc_f[1:0]!=0, or pc_f<PC_RESET, or pc_f>IM_TOP. When loading such a fetch:
  - instr_d=0, adel_d=1, pc_d=pc_f.
  - Fetch continues sequentially until the exception stage raises exc_req.
- Simultaneous exc_req and eret: exc_req wins.
- Simultaneous stall and npc_sel!=0: hold. The D instruction re-asserts its redirect next cycle.

## Timing
- Reset values, one edge after reset=0: pc_f=PC_RESET, instr_d=0, pc_d=0, bd_d=0, adel_d=0.
- Reset has priority over every other input.
- Reset asserted mid-stall or mid-redirect discards the pending redirect.
- pc_f is a register output. instr_f must settle within the same cycle.
- Fetch-to-D latency: 1 cycle.
- Redirect latency:
  - The target appears on pc_f on the edge after npc_sel is asserted.
  - The delay-slot instruction enters D on that same edge.
- Exception/ERET latency: 1 cycle to the new pc_f. The F/D register is flushed on the same edge.
- No combinational path from any input to pc_f.

## Configuration
- IFU_ADDR_CHECK_EN defined:
  - The address-error check is implemented.
  - adel_d is set as described, and the faulting instr_f is replaced by 0.
- Not defined:
  - adel_d is constant 0.
  - instr_f is always passed through.
  - No range comparators are synthesized.

## Structure
- Shared package cpu_pkg holds:
  - NPC_SEQ/NPC_BR/NPC_J/NPC_JR encodings for npc_sel
  - PC_RESET, EXC_VECTOR, IM_TOP constants, shared with the instruction memory and CP0
- One sub-module, npc_gen: a purely combinational next-PC mux and target adder.
- ifu holds the PC register, the F/D register and the address check.

## Test plan
- Reset low for 2 cycles, then release, sequential fetch → pc_f 0x3000, 0x3004, 0x3008; instr_d follows with 1-cycle lag; bd_d=0.
- With pc_d=0x3010, instr_d[15:0]=0xFFFE, npc_sel=01, jump_d=1:
  - next pc_f=0x300C
  - the instruction fetched at 0x3014 enters D with bd_d=1
- stall=1 for 3 cycles while npc_sel=10 → pc_f and all F/D outputs frozen; jump taken on the first cycle after stall drops.
- exc_req with stall=1 → pc_f=0x4180 next edge, instr_d=0, pc_d=0. Then eret with epc=0x3020 → pc_f=0x3020, F/D flushed.
- jr with rs_val=0x3002 (macro on):
  - pc_f=0x3002
  - next edge: adel_d=1, instr_d=0, pc_d=0x3002
  - with the macro off: adel_d=0 and instr_d=instr_f
- exc_req and eret together → pc_f=0x4180. reset asserted during a branch redirect → pc_f=0x3000.
